// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared widths and constants for the write-back register file and its
// pending-write scoreboard.
package wb_regfile_scoreboard_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NREGS = 2**DEF_ADDR_W;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per destination register plus a
// registered population count. An issue (set) wins over a same-cycle write-back (clear).
module wb_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_sel,
  input  logic                     i_clr_en,
  input  logic [ADDR_W-1:0]        i_clr_sel,
  output logic [(2**ADDR_W)-1:0]   o_pending,
  output logic [ADDR_W:0]          o_count
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_pending_next;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_next;
  logic                w_inc;
  logic                w_dec;

  // Decode set/clear requests; register 0 is never tracked.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (i_set_en && (i_set_sel != ADDR_W'(REG_ZERO))) begin
      w_set_vec = ONE_HOT0 << i_set_sel;
    end else begin
      w_set_vec = '0;
    end
    if (i_clr_en && (i_clr_sel != ADDR_W'(REG_ZERO))) begin
      w_clr_vec = ONE_HOT0 << i_clr_sel;
    end else begin
      w_clr_vec = '0;
    end
    w_pending_next = (r_pending & ~w_clr_vec) | w_set_vec;
    w_inc = |(w_set_vec & ~r_pending);
    w_dec = |(w_clr_vec & r_pending & ~w_set_vec);
    case ({w_inc, w_dec})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Pending vector and its running count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  assign o_pending = r_pending;
  assign o_count   = r_count;
endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back sink: 32x32 register file with write-through bypass on two
// registered read ports, and a stall driven by the pending-write scoreboard.
module wb_regfile_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadSelect1,
  input  logic [ADDR_W-1:0] ReadSelect2,
  input  logic [ADDR_W-1:0] IssueSelect,
  input  logic              IssueEnable,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] WriteSelect,
  input  logic              WriteEnable,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Stall,
  output logic [ADDR_W:0]   PendingCount
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_rd1;
  logic [DATA_W-1:0]   r_rd2;
  logic [DATA_W-1:0]   w_val1;
  logic [DATA_W-1:0]   w_val2;
  logic [NUM_REGS-1:0] w_pending;
  logic [ADDR_W:0]     w_count;
  logic                w_wr_hit1;
  logic                w_wr_hit2;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_stall;
  logic                w_wr_valid;

  assign w_wr_valid = WriteEnable && (WriteSelect != ZERO_SEL);
  assign w_wr_hit1  = WriteEnable && (WriteSelect == ReadSelect1);
  assign w_wr_hit2  = WriteEnable && (WriteSelect == ReadSelect2);

  // A source is hazardous only if pending and not being retired this cycle.
  always_comb begin
    w_haz1  = (ReadSelect1 != ZERO_SEL) && w_pending[ReadSelect1] && !w_wr_hit1;
    w_haz2  = (ReadSelect2 != ZERO_SEL) && w_pending[ReadSelect2] && !w_wr_hit2;
    w_stall = w_haz1 || w_haz2;
  end

  // Read value selection: r0 reads zero, then bypass, then the array.
  always_comb begin
    w_val1 = '0;
    w_val2 = '0;
    if (ReadSelect1 == ZERO_SEL) begin
      w_val1 = '0;
    end else if (w_wr_hit1) begin
      w_val1 = WriteData;
    end else begin
      w_val1 = r_regs[ReadSelect1];
    end
    if (ReadSelect2 == ZERO_SEL) begin
      w_val2 = '0;
    end else if (w_wr_hit2) begin
      w_val2 = WriteData;
    end else begin
      w_val2 = r_regs[ReadSelect2];
    end
  end

  // Register array commit; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[WriteSelect] <= WriteData;
    end
  end

  // Read ports hold while the front end is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else if (!w_stall) begin
      r_rd1 <= w_val1;
      r_rd2 <= w_val2;
    end
  end

  wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (IssueEnable && !w_stall),
    .i_set_sel (IssueSelect),
    .i_clr_en  (WriteEnable),
    .i_clr_sel (WriteSelect),
    .o_pending (w_pending),
    .o_count   (w_count)
  );

  assign ReadData1    = r_rd1;
  assign ReadData2    = r_rd2;
  assign Stall        = w_stall;
  assign PendingCount = w_count;
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: the driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_wb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ReadSelect1 = 5'd0;
  logic [4:0]  ReadSelect2 = 5'd0;
  logic [4:0]  IssueSelect = 5'd0;
  logic        IssueEnable = 1'b0;
  logic [31:0] WriteData = 32'd0;
  logic [4:0]  WriteSelect = 5'd0;
  logic        WriteEnable = 1'b0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Stall;
  logic [5:0]  PendingCount;

  int checks = 0;
  int errors = 0;

  // m[0] Stall (for this cycle's inputs), m[1] ReadData1, m[2] ReadData2,
  // m[3] PendingCount (all three as left by the previous cycle's inputs).
  typedef struct {
    string       nm;
    logic [3:0]  m;
    logic        st;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  wb_regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .ReadSelect1  (ReadSelect1),
    .ReadSelect2  (ReadSelect2),
    .IssueSelect  (IssueSelect),
    .IssueEnable  (IssueEnable),
    .WriteData    (WriteData),
    .WriteSelect  (WriteSelect),
    .WriteEnable  (WriteEnable),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .Stall        (Stall),
    .PendingCount (PendingCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Monitor: outputs are stable mid-cycle, away from the posedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.m[0]) begin
        checks++;
        if (Stall !== e.st) begin
          errors++;
          $display("FAIL %s stall: got %0b expected %0b", e.nm, Stall, e.st);
        end
      end
      if (e.m[1]) begin
        checks++;
        if (ReadData1 !== e.r1) begin
          errors++;
          $display("FAIL %s rd1: got %08h expected %08h", e.nm, ReadData1, e.r1);
        end
      end
      if (e.m[2]) begin
        checks++;
        if (ReadData2 !== e.r2) begin
          errors++;
          $display("FAIL %s rd2: got %08h expected %08h", e.nm, ReadData2, e.r2);
        end
      end
      if (e.m[3]) begin
        checks++;
        if (PendingCount !== e.cnt) begin
          errors++;
          $display("FAIL %s count: got %0d expected %0d", e.nm, PendingCount, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input string nm, input bit r, input bit [4:0] rs1, input bit [4:0] rs2,
                     input bit [4:0] isel, input bit ien, input bit [4:0] wsel, input bit wen,
                     input bit [31:0] wd, input bit [3:0] m, input bit est,
                     input bit [31:0] er1, input bit [31:0] er2, input bit [5:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ReadSelect1 = rs1; ReadSelect2 = rs2;
    IssueSelect = isel; IssueEnable = ien;
    WriteSelect = wsel; WriteEnable = wen; WriteData = wd;
    e.nm = nm; e.m = m; e.st = est; e.r1 = er1; e.r2 = er2; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  initial begin
    //  name        rst rs1 rs2 isel ien wsel wen wdata          mask  st rd1            rd2         cnt
    cyc("rst0",     1, 0,  0,  0,  0, 0,  0, 32'h0,         4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("rst1",     1, 0,  0,  0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h0,        32'h0,      6'd0);
    cyc("pre5",     0, 0,  0,  0,  0, 5,  1, 32'h11111111,  4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("pre31",    0, 0,  0,  0,  0, 31, 1, 32'h22222222,  4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("pre_iss",  0, 0,  0,  6,  1, 0,  0, 32'h0,         4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("rst_mid",  1, 0,  0,  0,  0, 0,  0, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("rst_sel",  0, 5,  31, 0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h0,        32'h0,      6'd0);
    cyc("rst_rd",   0, 0,  0,  0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h0,        32'h0,      6'd0);
    cyc("wr7",      0, 0,  0,  0,  0, 7,  1, 32'hDEADBEEF,  4'h1, 0, 32'h0,        32'h0,      6'd0);
    cyc("rd7_sel",  0, 7,  0,  0,  0, 0,  0, 32'h0,         4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("rd7",      0, 0,  0,  0,  0, 0,  0, 32'h0,         4'h2, 0, 32'hDEADBEEF, 32'h0,      6'd0);
    cyc("byp",      0, 0,  9,  0,  0, 9,  1, 32'h1234,      4'h1, 0, 32'h0,        32'h0,      6'd0);
    cyc("byp_rd",   0, 0,  0,  0,  0, 0,  0, 32'h0,         4'h4, 0, 32'h0,        32'h1234,   6'd0);
    cyc("wr0",      0, 7,  0,  0,  0, 0,  1, 32'hFFFFFFFF,  4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("rd0_sel",  0, 0,  0,  0,  0, 0,  0, 32'h0,         4'h2, 0, 32'hDEADBEEF, 32'h0,      6'd0);
    cyc("iss0",     0, 0,  0,  0,  1, 0,  0, 32'h0,         4'h2, 0, 32'h0,        32'h0,      6'd0);
    cyc("iss0_cnt", 0, 0,  0,  0,  0, 0,  0, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd0);
    cyc("iss3",     0, 7,  0,  3,  1, 0,  0, 32'h0,         4'h1, 0, 32'h0,        32'h0,      6'd0);
    cyc("haz3a",    0, 3,  0,  0,  0, 0,  0, 32'h0,         4'hF, 1, 32'hDEADBEEF, 32'h0,      6'd1);
    cyc("haz3b",    0, 3,  0,  0,  0, 0,  0, 32'h0,         4'hF, 1, 32'hDEADBEEF, 32'h0,      6'd1);
    cyc("wb3",      0, 3,  0,  0,  0, 3,  1, 32'h55,        4'hF, 0, 32'hDEADBEEF, 32'h0,      6'd1);
    cyc("wb3_rd",   0, 0,  0,  0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h55,       32'h0,      6'd0);
    cyc("iss4",     0, 0,  0,  4,  1, 0,  0, 32'h0,         4'h1, 0, 32'h0,        32'h0,      6'd0);
    cyc("iss_wb4",  0, 0,  0,  4,  1, 4,  1, 32'hAA,        4'h9, 0, 32'h0,        32'h0,      6'd1);
    cyc("haz4a",    0, 4,  0,  0,  0, 0,  0, 32'h0,         4'h9, 1, 32'h0,        32'h0,      6'd1);
    cyc("haz4b",    0, 4,  0,  0,  0, 0,  0, 32'h0,         4'hF, 1, 32'h0,        32'h0,      6'd1);
    cyc("wb4",      0, 4,  0,  0,  0, 4,  1, 32'hBB,        4'h1, 0, 32'h0,        32'h0,      6'd0);
    cyc("wb4_rd",   0, 0,  0,  0,  0, 0,  0, 32'h0,         4'hF, 0, 32'hBB,       32'h0,      6'd0);
    cyc("iss10",    0, 0,  0,  10, 1, 0,  0, 32'h0,         4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("reiss10",  0, 0,  0,  10, 1, 0,  0, 32'h0,         4'h9, 0, 32'h0,        32'h0,      6'd1);
    cyc("iss11",    0, 0,  0,  11, 1, 0,  0, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("haz10",    0, 0,  10, 0,  0, 0,  0, 32'h0,         4'h9, 1, 32'h0,        32'h0,      6'd2);
    cyc("rst_fly",  1, 0,  10, 13, 1, 12, 1, 32'h77,        4'h9, 1, 32'h0,        32'h0,      6'd2);
    cyc("post_rst", 0, 12, 10, 0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h0,        32'h0,      6'd0);
    cyc("post_rd",  0, 0,  0,  0,  0, 0,  0, 32'h0,         4'hF, 0, 32'h0,        32'h0,      6'd0);
    cyc("iss20",    0, 0,  0,  20, 1, 0,  0, 32'h0,         4'h0, 0, 32'h0,        32'h0,      6'd0);
    cyc("i21_w20",  0, 0,  0,  21, 1, 20, 1, 32'h1,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("wb22",     0, 0,  0,  0,  0, 22, 1, 32'h5,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("idle",     0, 0,  0,  0,  0, 0,  0, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("wb21",     0, 0,  0,  0,  0, 21, 1, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd1);
    cyc("rd22_sel", 0, 22, 0,  0,  0, 0,  0, 32'h0,         4'h8, 0, 32'h0,        32'h0,      6'd0);
    cyc("rd22",     0, 0,  0,  0,  0, 0,  0, 32'h0,         4'hA, 0, 32'h5,        32'h0,      6'd0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- Write-back sink of the 3-stage datapath. Consumes the stage-3 write port (data, 5-bit select, enable) and commits it into a 32x32 register file.
- Serves two registered read ports to the stage-2 register, with same-cycle write-through bypass.
- Keeps a pending-write scoreboard of destinations that are in flight. It raises Stall when a read source is still pending.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register select width; NREGS = 2**ADDR_W entries

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- ReadSelect1  input  ADDR_W  source register A for the instruction entering stage 2
- ReadSelect2  input  ADDR_W  source register B
- IssueSelect  input  ADDR_W  destination of the instruction entering stage 2
- IssueEnable  input  1  that instruction will write IssueSelect
- WriteData  input  DATA_W  write-back data (stage-3 ALU result)
- WriteSelect  input  ADDR_W  write-back destination (stage-3 write select)
- WriteEnable  input  1  write-back strobe (stage-3 write enable)
- ReadData1  output  DATA_W  registered value of ReadSelect1
- ReadData2  output  DATA_W  registered value of ReadSelect2
- Stall  output  1  combinational; hold the front end this cycle
- PendingCount  output  ADDR_W+1  registered count of set scoreboard bits

Behaviour:
- Reset (rst high at posedge): all NREGS registers <= 0, all pending bits <= 0, ReadData1/2 <= 0, PendingCount <= 0. Reset overrides every other input in that cycle, including mid-flight writes and issues; those are dropped.
- Register 0:
  - reads always return 0
  - writes to it are ignored
  - its pending bit is never set
- Write: on posedge with WriteEnable=1 and WriteSelect!=0, regs[WriteSelect] <= WriteData and pending[WriteSelect] is cleared. WriteEnable=0 leaves the file and scoreboard unchanged.
- Read latency is 1 cycle. On posedge with Stall=0, ReadDataN <= value(ReadSelectN), where value() is:
  - 0 if the select is 0
  - otherwise WriteData if WriteEnable=1 and WriteSelect==ReadSelectN (bypass)
  - otherwise regs[ReadSelectN]
- Stall=1: ReadData1/2 hold their previous values.
- Hazard term: hazN = (ReadSelectN!=0) and pending[ReadSelectN] and not (WriteEnable and WriteSelect==ReadSelectN).
- Stall = haz1 or haz2. It is purely combinational, with no dependence on IssueSelect.
- Issue: on posedge with IssueEnable=1, Stall=0 and IssueSelect!=0, pending[IssueSelect] <= 1. Issue while Stall=1 is ignored.
- Simultaneous issue and write-back to the same register: set wins, so the bit stays 1. The newer producer is still in flight.
- Re-issue to an already-pending register: the bit stays 1. There is no counting per register; in-order single issue guarantees the later write-back is the last.
- PendingCount tracks the popcount of pending[] after each update:
  - +1 for an accepted set of a clear bit
  - -1 for a clear of a set bit that is not re-set in the same cycle
  - range 0..NREGS-1, so it never wraps
- A write-back to a non-pending register is legal. It updates data only; the count is unchanged.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults
  - the REG_ZERO constant (5'd0)
  - a localparam NREGS
  - no typedefs beyond these widths
- One sub-module is natural: wb_scoreboard.
  - Holds the pending[] vector, the set/clear priority and PendingCount.
  - Exports pending[] to the parent, which computes Stall.
- The storage array, bypass mux and read registers stay in the top module.

Test Plan:
- Reset: preload regs via writes, then assert rst for 1 cycle. The next reads of r5 and r31 return 0; PendingCount=0; Stall=0.
- Write/read: write 0xDEADBEEF to r7, then read r7 on the following cycle. ReadData1=0xDEADBEEF one cycle after the select is applied.
- Bypass: in the same cycle, WriteEnable=1, WriteSelect=9, WriteData=0x1234 and ReadSelect2=9. The next cycle ReadData2=0x1234 and Stall=0.
- r0 rules:
  - write 0xFFFFFFFF to r0, then read r0 -> 0
  - IssueEnable with IssueSelect=0 -> PendingCount stays 0
- Hazard:
  - issue r3; the next cycle ReadSelect1=3 -> Stall=1 and ReadData1 holds its value
  - write-back r3=0x55 -> Stall=0 that cycle, ReadData1=0x55 the next cycle, PendingCount 1->0
- Priority: pending[4]=1; same-cycle IssueSelect=4 and WriteSelect=4 with data 0xAA.
  - pending[4] stays 1, PendingCount unchanged
  - a later read of r4 stalls until a second write-back
  - rst asserted mid-sequence clears all state
